// File: rtl/cbpa_pkg.sv
// Shared definitions for the pipelined carry-bypass adder/subtractor:
// operation encoding and the parameter legality check used at elaboration.
package cbpa_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Every stage must split evenly into whole carry-bypass groups.
  function automatic bit cbpa_params_ok(input int width, input int block, input int stages);
    if (stages < 1 || block < 1 || width < 1) return 1'b0;
    return (width % (stages * block)) == 0;
  endfunction

endpackage

// File: rtl/cbpa_seg.sv
// Combinational SEG_W-bit carry-bypass adder built from BLOCK-bit groups.
// Also exposes the carry into the segment MSB for overflow detection.
module cbpa_seg #(
  parameter int SEG_W = 16,
  parameter int BLOCK = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  localparam int NG = SEG_W / BLOCK;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] gn;
    logic [BLOCK:0]   c;
    logic             gci;
    logic             gco;

    if (g == 0) begin : g_first
      assign gci = ci;
    end else begin : g_next
      assign gci = g_grp[g-1].gco;
    end

    assign p  = a[g*BLOCK +: BLOCK] ^ b[g*BLOCK +: BLOCK];
    assign gn = a[g*BLOCK +: BLOCK] & b[g*BLOCK +: BLOCK];

    always_comb begin
      c    = '0;
      c[0] = gci;
      for (int i = 0; i < BLOCK; i++) begin
        c[i+1] = gn[i] | (p[i] & c[i]);
      end
    end

    assign s[g*BLOCK +: BLOCK] = p ^ c[BLOCK-1:0];
    // A fully propagating group forwards its carry-in directly, skipping the ripple.
    assign gco = (&p) ? gci : c[BLOCK];
  end

  assign co       = g_grp[NG-1].gco;
  assign c_msb_in = g_grp[NG-1].c[BLOCK-1];

endmodule

// File: rtl/cbpa_pipe.sv
// Pipelined carry-bypass adder/subtractor: STAGES registered segments with a
// valid/ready handshake on both sides and a single global advance enable.
module cbpa_pipe
  import cbpa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  localparam int SEG_W = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

  if (!cbpa_params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_params
    $fatal(1, "cbpa_pipe: WIDTH must be a multiple of STAGES*BLOCK and STAGES >= 1");
  end

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + !cin, so borrow-in maps to an inverted carry-in.
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c_eff = (op == OP_SUB) ? ~cin : cin;

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int HI = (k + 1) * SEG_W;

    logic [SEG_W-1:0] sa;
    logic [SEG_W-1:0] sb;
    logic [SEG_W-1:0] ss;
    logic             sci;
    logic             sco;
    logic             smsb;
    logic [HI-1:0]    s_d;
    logic [HI-1:0]    s_q;
    logic             c_q;

    if (k == 0) begin : g_head
      assign sa  = a[SEG_W-1:0];
      assign sb  = b_eff[SEG_W-1:0];
      assign sci = c_eff;
      assign s_d = ss;
    end else begin : g_body
      assign sa  = g_stg[k-1].g_pass.a_q[SEG_W-1:0];
      assign sb  = g_stg[k-1].g_pass.b_q[SEG_W-1:0];
      assign sci = g_stg[k-1].c_q;
      assign s_d = {ss, g_stg[k-1].s_q};
    end

    cbpa_seg #(
      .SEG_W (SEG_W),
      .BLOCK (BLOCK)
    ) u_seg (
      .a        (sa),
      .b        (sb),
      .ci       (sci),
      .s        (ss),
      .co       (sco),
      .c_msb_in (smsb)
    );

    if (k < STAGES - 1) begin : g_pass
      localparam int UP = WIDTH - HI;

      logic [UP-1:0] a_d;
      logic [UP-1:0] b_d;
      logic [UP-1:0] a_q;
      logic [UP-1:0] b_q;

      // Only the operand bits not yet consumed travel forward with the beat.
      if (k == 0) begin : g_src0
        assign a_d = a[WIDTH-1:HI];
        assign b_d = b_eff[WIDTH-1:HI];
      end else begin : g_srcn
        assign a_d = g_stg[k-1].g_pass.a_q[UP+SEG_W-1:SEG_W];
        assign b_d = g_stg[k-1].g_pass.b_q[UP+SEG_W-1:SEG_W];
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
          s_q <= s_d;
          c_q <= sco;
        end
      end
    end else begin : g_last
      logic of_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q  <= '0;
          c_q  <= 1'b0;
          of_q <= 1'b0;
        end else if (adv) begin
          s_q  <= s_d;
          c_q  <= sco;
          of_q <= smsb ^ sco;
        end
      end
    end
  end

  assign sum  = g_stg[STAGES-1].s_q;
  assign cout = g_stg[STAGES-1].c_q;
  assign of   = g_stg[STAGES-1].g_last.of_q;

endmodule

// File: tb/tb_cbpa_pipe.sv
// Directed bench for cbpa_pipe (WIDTH=32, BLOCK=4, STAGES=2): arithmetic
// corner cases, latency, back-to-back streaming with a stall, and async reset.
module tb_cbpa_pipe;
  import cbpa_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        of;

  int n_chk;
  int n_fail;

  cbpa_pipe #(
    .WIDTH  (32),
    .BLOCK  (4),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .of        (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One isolated beat: checks acceptance, exact two-cycle latency and the result.
  task automatic run_beat(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic top, input logic [31:0] es,
                          input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; op = top; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_of"}, {31'd0, of}, {31'd0, eo});
  endtask

  logic [31:0] exp_s [4];
  int tx, rx, stall_n;
  logic acc, took;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = OP_ADD; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_of", {31'd0, of}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    run_beat("add_pos_of",  32'h7fffffff, 32'h7fffffff, 1'b0, OP_ADD, 32'hfffffffe, 1'b0, 1'b1);
    run_beat("add_neg_of",  32'h8fffffff, 32'h8fffffff, 1'b0, OP_ADD, 32'h1ffffffe, 1'b1, 1'b1);
    run_beat("add_wrap",    32'hffffffff, 32'h00000000, 1'b1, OP_ADD, 32'h00000000, 1'b1, 1'b0);
    run_beat("add_segc",    32'h0000ffff, 32'h00000001, 1'b0, OP_ADD, 32'h00010000, 1'b0, 1'b0);
    run_beat("add_m1",      32'h000007aa, 32'hffffffff, 1'b0, OP_ADD, 32'h000007a9, 1'b1, 1'b0);
    run_beat("sub_borrow",  32'h00000000, 32'h00000001, 1'b0, OP_SUB, 32'hffffffff, 1'b0, 1'b0);
    run_beat("sub_of",      32'h80000000, 32'h00000001, 1'b0, OP_SUB, 32'h7fffffff, 1'b1, 1'b1);
    run_beat("sub_bin",     32'h00000010, 32'h00000005, 1'b1, OP_SUB, 32'h0000000a, 1'b1, 1'b0);

    // Stream: beat i is 0x1000ffff+i plus 1+i, i.e. 0x10010000 + 2*i.
    for (int i = 0; i < 4; i++) exp_s[i] = 32'h10010000 + 32'(2 * i);
    tx = 0; rx = 0; stall_n = 0;
    for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(out_valid && rx == 1 && stall_n < 3);
      if (!out_ready) stall_n++;
      in_valid = (tx < 4);
      a = 32'h1000ffff + 32'(tx); b = 32'h00000001 + 32'(tx); cin = 1'b0; op = OP_ADD;
      #1;
      if (out_valid) chk($sformatf("strm_sum%0d", rx), sum, exp_s[rx]);
      if (!out_ready) chk("strm_stall_in_ready", {31'd0, in_ready}, 32'd0);
      acc  = in_valid && in_ready;
      took = out_valid && out_ready;
      @(posedge clk);
      if (acc) tx++;
      if (took) rx++;
    end
    #1 in_valid = 1'b0; out_ready = 1'b1;
    chk("strm_rx_count", 32'(rx), 32'd4);
    chk("strm_tx_count", 32'(tx), 32'd4);
    chk("strm_stalls", 32'(stall_n), 32'd3);
    repeat (3) begin
      @(negedge clk);
      chk("strm_no_dup", {31'd0, out_valid}, 32'd0);
    end

    // Two beats in flight, then reset asynchronously between clock edges.
    @(negedge clk);
    a = 32'h1; b = 32'h2; cin = 1'b0; op = OP_ADD; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h3; b = 32'h4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_sum", sum, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_after", {31'd0, out_valid}, 32'd0);
    end
    run_beat("post_rst", 32'h12345678, 32'h11111111, 1'b0, OP_ADD, 32'h23456789, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
